// File: rtl/voice_allocator_pkg.sv
// Shared definitions for the voice allocator: key-state encoding and the
// note-to-divider lookup table used by every voice.
package voice_allocator_pkg;

  localparam int KEY_W   = 4;
  localparam int SPEED_W = 8;

  // A key is either idle, holding a voice, or was robbed of its voice and
  // must be released before it may claim another one.
  typedef enum logic [1:0] {
    KEY_FREE   = 2'd0,
    KEY_OWNED  = 2'd1,
    KEY_STOLEN = 2'd2
  } key_state_e;

  // Divider value for each key, C4 through C5.
  function automatic logic [SPEED_W-1:0] note_speed(input logic [KEY_W-1:0] key_idx);
    case (key_idx)
      4'd0:    return 8'd186;
      4'd1:    return 8'd176;
      4'd2:    return 8'd166;
      4'd3:    return 8'd157;
      4'd4:    return 8'd148;
      4'd5:    return 8'd139;
      4'd6:    return 8'd132;
      4'd7:    return 8'd124;
      4'd8:    return 8'd117;
      4'd9:    return 8'd111;
      4'd10:   return 8'd104;
      4'd11:   return 8'd98;
      4'd12:   return 8'd93;
      default: return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/voice_age_tracker.sv
// Keeps a dense age rank per voice (0 = newest) and reports the oldest voice.
module voice_age_tracker
  import voice_allocator_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int RANK_W     = $clog2(NUM_VOICES)
) (
  input  logic                         clk_50MHz,
  input  logic                         reset_n,
  input  logic [NUM_VOICES-1:0]        active,
  input  logic                         alloc_en,
  input  logic                         release_en,
  input  logic [RANK_W-1:0]            voice_idx,
  output logic [NUM_VOICES*RANK_W-1:0] rank,
  output logic [RANK_W-1:0]            oldest_idx
);

  logic [RANK_W-1:0] rank_q [NUM_VOICES];
  logic [RANK_W-1:0] rank_d [NUM_VOICES];

  // Age the other voices when one is (re)allocated, close the gap when one is released.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      rank_d[v] = rank_q[v];
    end
    if (alloc_en) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (v != int'(voice_idx) && active[v] &&
            (!active[voice_idx] || rank_q[v] < rank_q[voice_idx])) begin
          rank_d[v] = rank_q[v] + 1'b1;
        end
      end
      rank_d[voice_idx] = '0;
    end else if (release_en) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (v != int'(voice_idx) && active[v] && rank_q[v] > rank_q[voice_idx]) begin
          rank_d[v] = rank_q[v] - 1'b1;
        end
      end
      rank_d[voice_idx] = '0;
    end
  end

  // The oldest voice is the active one carrying the highest possible rank.
  always_comb begin
    oldest_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      rank[v*RANK_W +: RANK_W] = rank_q[v];
      if (active[v] && rank_q[v] == RANK_W'(NUM_VOICES-1)) begin
        oldest_idx = RANK_W'(v);
      end
    end
  end

  // Rank registers.
  always_ff @(posedge clk_50MHz) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!reset_n) begin
        rank_q[v] <= '0;
      end else begin
        rank_q[v] <= rank_d[v];
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// Scans the keyboard one key per cycle and hands out a small pool of voices,
// stealing the oldest voice when the pool is exhausted.
module voice_allocator
  import voice_allocator_pkg::*;
#(
  parameter int NUM_KEYS   = 13,
  parameter int NUM_VOICES = 4
) (
  input  logic                          clk_50MHz,
  input  logic                          reset_n,
  input  logic [NUM_KEYS-1:0]           keys,
  output logic [NUM_VOICES-1:0]         voice_active,
  output logic [KEY_W*NUM_VOICES-1:0]   voice_key,
  output logic [SPEED_W*NUM_VOICES-1:0] voice_speed,
  output logic                          steal_pulse,
  output logic [2:0]                    busy_count
);

  localparam int SCAN_W = $clog2(NUM_KEYS);
  localparam int VW     = $clog2(NUM_VOICES);

  logic [SCAN_W-1:0]     scan_idx_q, scan_idx_d;
  key_state_e            key_state_q [NUM_KEYS];
  key_state_e            key_state_d [NUM_KEYS];
  logic [VW-1:0]         key_owner_q [NUM_KEYS];
  logic [VW-1:0]         key_owner_d [NUM_KEYS];
  logic [NUM_VOICES-1:0] voice_active_q, voice_active_d;
  logic [KEY_W-1:0]      voice_key_q [NUM_VOICES];
  logic [KEY_W-1:0]      voice_key_d [NUM_VOICES];
  logic [SPEED_W-1:0]    voice_speed_q [NUM_VOICES];
  logic [SPEED_W-1:0]    voice_speed_d [NUM_VOICES];
  logic                  steal_pulse_q, steal_pulse_d;
  logic [2:0]            busy_count_q, busy_count_d;

  logic                       alloc_en, release_en, any_free, oldest_ok;
  logic [VW-1:0]              voice_sel, free_idx, oldest_idx;
  logic [NUM_VOICES*VW-1:0]   rank_vec;

  voice_age_tracker #(
    .NUM_VOICES (NUM_VOICES),
    .RANK_W     (VW)
  ) u_age (
    .clk_50MHz  (clk_50MHz),
    .reset_n    (reset_n),
    .active     (voice_active_q),
    .alloc_en   (alloc_en),
    .release_en (release_en),
    .voice_idx  (voice_sel),
    .rank       (rank_vec),
    .oldest_idx (oldest_idx)
  );

  // Find the lowest-numbered idle voice; only steal when the tracker reports a genuine oldest.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int v = NUM_VOICES-1; v >= 0; v--) begin
      if (!voice_active_q[v]) begin
        any_free = 1'b1;
        free_idx = VW'(v);
      end
    end
    oldest_ok = (rank_vec[oldest_idx*VW +: VW] == VW'(NUM_VOICES-1));
  end

  // Evaluate the key under the scan pointer: allocate, steal, release or forget a steal.
  always_comb begin
    scan_idx_d     = (scan_idx_q == SCAN_W'(NUM_KEYS-1)) ? '0 : scan_idx_q + 1'b1;
    key_state_d    = key_state_q;
    key_owner_d    = key_owner_q;
    voice_active_d = voice_active_q;
    voice_key_d    = voice_key_q;
    voice_speed_d  = voice_speed_q;
    steal_pulse_d  = 1'b0;
    alloc_en       = 1'b0;
    release_en     = 1'b0;
    voice_sel      = '0;
    case (key_state_q[scan_idx_q])
      KEY_FREE: begin
        if (keys[scan_idx_q]) begin
          if (any_free) begin
            voice_sel = free_idx;
            alloc_en  = 1'b1;
          end else if (oldest_ok) begin
            voice_sel     = oldest_idx;
            alloc_en      = 1'b1;
            steal_pulse_d = 1'b1;
            key_state_d[voice_key_q[oldest_idx]] = KEY_STOLEN;
          end
          if (alloc_en) begin
            key_state_d[scan_idx_q]  = KEY_OWNED;
            key_owner_d[scan_idx_q]  = voice_sel;
            voice_active_d[voice_sel] = 1'b1;
            voice_key_d[voice_sel]    = KEY_W'(scan_idx_q);
            voice_speed_d[voice_sel]  = note_speed(KEY_W'(scan_idx_q));
          end
        end
      end
      KEY_OWNED: begin
        if (!keys[scan_idx_q]) begin
          voice_sel                 = key_owner_q[scan_idx_q];
          release_en                = 1'b1;
          key_state_d[scan_idx_q]   = KEY_FREE;
          voice_active_d[voice_sel] = 1'b0;
          voice_key_d[voice_sel]    = '0;
          voice_speed_d[voice_sel]  = '0;
        end
      end
      KEY_STOLEN: begin
        if (!keys[scan_idx_q]) begin
          key_state_d[scan_idx_q] = KEY_FREE;
        end
      end
      default: key_state_d[scan_idx_q] = KEY_FREE;
    endcase
    busy_count_d = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      busy_count_d = busy_count_d + 3'(voice_active_d[v]);
    end
  end

  // State and output registers.
  always_ff @(posedge clk_50MHz) begin
    if (!reset_n) begin
      scan_idx_q     <= '0;
      voice_active_q <= '0;
      steal_pulse_q  <= 1'b0;
      busy_count_q   <= '0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        key_state_q[k] <= KEY_FREE;
        key_owner_q[k] <= '0;
      end
      for (int v = 0; v < NUM_VOICES; v++) begin
        voice_key_q[v]   <= '0;
        voice_speed_q[v] <= '0;
      end
    end else begin
      scan_idx_q     <= scan_idx_d;
      voice_active_q <= voice_active_d;
      steal_pulse_q  <= steal_pulse_d;
      busy_count_q   <= busy_count_d;
      key_state_q    <= key_state_d;
      key_owner_q    <= key_owner_d;
      voice_key_q    <= voice_key_d;
      voice_speed_q  <= voice_speed_d;
    end
  end

  // Flatten the per-voice registers onto the output buses.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      voice_key[v*KEY_W +: KEY_W]       = voice_key_q[v];
      voice_speed[v*SPEED_W +: SPEED_W] = voice_speed_q[v];
    end
  end

  assign voice_active = voice_active_q;
  assign steal_pulse  = steal_pulse_q;
  assign busy_count   = busy_count_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Randomised and directed bench for voice_allocator with a queue-based
// reference model and a scoreboard monitor.
module tb_voice_allocator;

  localparam int NK = 13;
  localparam int NV = 4;
  localparam int FREE = 0, OWNED = 1, STOLEN = 2;

  logic            clk_50MHz = 1'b0;
  logic            reset_n   = 1'b0;
  logic [NK-1:0]   keys      = '0;
  logic [NV-1:0]   voice_active;
  logic [4*NV-1:0] voice_key;
  logic [8*NV-1:0] voice_speed;
  logic            steal_pulse;
  logic [2:0]      busy_count;

  voice_allocator #(.NUM_KEYS(NK), .NUM_VOICES(NV)) dut (
    .clk_50MHz    (clk_50MHz),
    .reset_n      (reset_n),
    .keys         (keys),
    .voice_active (voice_active),
    .voice_key    (voice_key),
    .voice_speed  (voice_speed),
    .steal_pulse  (steal_pulse),
    .busy_count   (busy_count)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  typedef struct {
    logic [NV-1:0]   act;
    logic [4*NV-1:0] vkey;
    logic [8*NV-1:0] spd;
    logic            steal;
    logic [2:0]      busy;
    logic [2*NV-1:0] rank;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   steals_seen = 0;

  logic          stim_rst_n = 1'b0;
  logic [NK-1:0] stim_keys  = '0;

  int speed_tab [NK] = '{186, 176, 166, 157, 148, 139, 132, 124, 117, 111, 104, 98, 93};

  // Reference model: key bookkeeping plus an age list with the newest voice in front.
  int m_scan;
  int m_kstate [NK];
  int m_owner  [NK];
  bit m_act    [NV];
  int m_vkey   [NV];
  int m_age[$];
  bit m_steal;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic age_remove(input int v);
    for (int i = 0; i < m_age.size(); i++) begin
      if (m_age[i] == v) begin
        m_age.delete(i);
        break;
      end
    end
  endtask

  task automatic model_step(input logic rn, input logic [NK-1:0] k);
    m_steal = 1'b0;
    if (!rn) begin
      m_scan = 0;
      for (int i = 0; i < NK; i++) begin m_kstate[i] = FREE; m_owner[i] = 0; end
      for (int v = 0; v < NV; v++) begin m_act[v] = 0; m_vkey[v] = 0; end
      m_age.delete();
    end else begin
      int v;
      v = -1;
      if (m_kstate[m_scan] == FREE && k[m_scan]) begin
        for (int i = NV-1; i >= 0; i--) if (!m_act[i]) v = i;
        if (v < 0) begin
          v = m_age[m_age.size()-1];
          m_age.pop_back();
          m_kstate[m_vkey[v]] = STOLEN;
          m_steal = 1'b1;
        end
        m_age.push_front(v);
        m_act[v] = 1;
        m_vkey[v] = m_scan;
        m_kstate[m_scan] = OWNED;
        m_owner[m_scan] = v;
      end else if (m_kstate[m_scan] == OWNED && !k[m_scan]) begin
        v = m_owner[m_scan];
        age_remove(v);
        m_act[v] = 0;
        m_vkey[v] = 0;
        m_kstate[m_scan] = FREE;
      end else if (m_kstate[m_scan] == STOLEN && !k[m_scan]) begin
        m_kstate[m_scan] = FREE;
      end
      m_scan = (m_scan + 1) % NK;
    end
  endtask

  function automatic exp_t build_expected();
    exp_t e;
    e.act = '0; e.vkey = '0; e.spd = '0; e.rank = '0;
    e.steal = m_steal;
    e.busy = 3'(m_age.size());
    for (int v = 0; v < NV; v++) begin
      if (m_act[v]) begin
        e.act[v] = 1'b1;
        e.vkey[v*4 +: 4] = 4'(m_vkey[v]);
        e.spd[v*8 +: 8] = 8'(speed_tab[m_vkey[v]]);
      end
    end
    for (int i = 0; i < m_age.size(); i++) e.rank[m_age[i]*2 +: 2] = 2'(i);
    return e;
  endfunction

  // Driver: on every falling edge apply the pending stimulus and queue the model's prediction.
  task automatic apply_stimulus();
    reset_n = stim_rst_n;
    keys    = stim_keys;
    model_step(stim_rst_n, stim_keys);
    exp_q.push_back(build_expected());
  endtask

  initial begin
    forever begin
      @(negedge clk_50MHz);
      apply_stimulus();
    end
  end

  // Monitor: just after each rising edge, compare the DUT against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_50MHz);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (steal_pulse === 1'b1) steals_seen++;
        check_output("voice_active", 32'(voice_active), 32'(e.act));
        check_output("voice_key", 32'(voice_key), 32'(e.vkey));
        check_output("voice_speed", voice_speed, e.spd);
        check_output("steal_pulse", 32'(steal_pulse), 32'(e.steal));
        check_output("busy_count", 32'(busy_count), 32'(e.busy));
        check_output("rank", 32'(dut.u_age.rank), 32'(e.rank));
      end
    end
  end

  // Present a stimulus for exactly n rising edges; returns just after the last one.
  task automatic hold(input logic rn, input logic [NK-1:0] k, input int n);
    stim_rst_n = rn;
    stim_keys  = k;
    repeat (n) begin
      @(posedge clk_50MHz);
      #2;
    end
  endtask

  initial begin
    logic [NK-1:0] held;
    int            s0;
    int            rmask;
    @(posedge clk_50MHz);
    #2;

    hold(1'b0, '0, 3);
    check_output("reset_active", 32'(voice_active), 32'd0);
    check_output("reset_busy", 32'(busy_count), 32'd0);

    hold(1'b1, 13'b0_0000_0000_0001, 14);
    check_output("c4_active", 32'(voice_active[0]), 32'd1);
    check_output("c4_key", 32'(voice_key[3:0]), 32'd0);
    check_output("c4_speed", 32'(voice_speed[7:0]), 32'd186);
    check_output("c4_busy", 32'(busy_count), 32'd1);

    held = 13'b0_0000_1001_0101;
    hold(1'b1, held, 13);
    check_output("four_busy", 32'(busy_count), 32'd4);
    s0 = steals_seen;
    held[9] = 1'b1;
    hold(1'b1, held, 13);
    check_output("steal_count", 32'(steals_seen - s0), 32'd1);
    check_output("steal_key", 32'(voice_key[3:0]), 32'd9);
    check_output("steal_speed", 32'(voice_speed[7:0]), 32'd111);

    s0 = steals_seen;
    hold(1'b1, held, 5*NK);
    check_output("no_thrash", 32'(steals_seen - s0), 32'd0);
    held[0] = 1'b0;
    hold(1'b1, held, NK);
    held[0] = 1'b1;
    hold(1'b1, held, NK);
    check_output("resteal_key", 32'(voice_key[7:4]), 32'd0);
    check_output("resteal_speed", 32'(voice_speed[15:8]), 32'd186);

    held[4] = 1'b0;
    hold(1'b1, held, NK);
    check_output("rel_active", 32'(voice_active[2]), 32'd0);
    check_output("rel_busy", 32'(busy_count), 32'd3);
    rmask = 0;
    for (int v = 0; v < NV; v++) begin
      if (voice_active[v]) rmask = rmask | (1 << int'(dut.u_age.rank[v*2 +: 2]));
    end
    check_output("rel_dense", 32'(rmask), 32'd7);

    held[4] = 1'b1;
    hold(1'b1, held, NK);
    hold(1'b0, held, 1);
    check_output("rst_active", 32'(voice_active), 32'd0);
    check_output("rst_speed", voice_speed, 32'd0);
    hold(1'b1, held, 1);
    check_output("post_rst_active", 32'(voice_active), 32'd1);
    check_output("post_rst_key", 32'(voice_key[3:0]), 32'd0);

    for (int seg = 0; seg < 80; seg++) begin
      logic          rn;
      logic [NK-1:0] k;
      int            len;
      rn  = ($urandom_range(0, 15) != 0);
      k   = NK'($urandom_range(0, 8191));
      if ($urandom_range(0, 2) == 0) k = k & NK'($urandom_range(0, 8191));
      len = rn ? $urandom_range(1, 40) : $urandom_range(1, 2);
      hold(rn, k, len);
    end

    hold(1'b1, '0, 2*NK);
    $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
